// File: rtl/main_memory_responder.sv
// Round-robin responder letting NUM_PORTS processing blocks share one row-wide main memory.
// Optional macro MEMRESP_OOR_ERR_EN adds the sticky oor_err / oor_port out-of-range report.
module main_memory_responder #(
    parameter int NUM_PORTS    = 4,
    parameter int LANES        = 32,
    parameter int LANE_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2,
    localparam int PW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                load_ctrl,
    input  logic [NUM_PORTS*ADDR_W-1:0]         load_addr,
    output logic [NUM_PORTS*LANES*LANE_W-1:0]   load_data,
    output logic [NUM_PORTS-1:0]                load_valid,
    input  logic [NUM_PORTS-1:0]                write_ctrl,
    input  logic [NUM_PORTS*ADDR_W-1:0]         write_addr,
    input  logic [NUM_PORTS*LANES*LANE_W-1:0]   write_data,
    output logic [NUM_PORTS-1:0]                write_ack,
`ifdef MEMRESP_OOR_ERR_EN
    output logic                                oor_err,
    output logic [PW-1:0]                       oor_port,
`endif
    output logic                                busy
);

    localparam int W  = LANES * LANE_W;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int L  = READ_LATENCY;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]    ldAddr [NUM_PORTS];
    logic [ADDR_W-1:0]    wrAddr [NUM_PORTS];
    logic [W-1:0]         wrData [NUM_PORTS];

    logic [W-1:0]         mem [DEPTH];

    logic [PW-1:0]        ptr_q, ptr_d;
    logic [L-1:0]         pipeValid_q, pipeValid_d;
    logic [PW-1:0]        pipePort_q [L];
    logic [PW-1:0]        pipePort_d [L];
    logic [ADDR_W-1:0]    pipeAddr_q [L];
    logic [ADDR_W-1:0]    pipeAddr_d [L];
    logic [W-1:0]         pipeData_q [L];
    logic [W-1:0]         pipeData_d [L];
    logic [W-1:0]         held_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] rdServed_q, rdServed_d;
    logic [NUM_PORTS-1:0] wrServed_q, wrServed_d;
    logic [NUM_PORTS-1:0] ack_q, ack_d;
    logic [ADDR_W-1:0]    rdAddr_q [NUM_PORTS];
    logic [ADDR_W-1:0]    rdAddr_d [NUM_PORTS];
    logic [ADDR_W-1:0]    wrSrvAddr_q [NUM_PORTS];
    logic [ADDR_W-1:0]    wrSrvAddr_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] inFlight, wantRead, wantWrite, eligible;
    logic                 grantValid, grantIsWrite, grantInRange;
    logic [PW-1:0]        grantPort;
    logic [ADDR_W-1:0]    grantAddr;
    logic [IW-1:0]        grantIdx;
    logic [W-1:0]         readRow;

    logic                 outValid;
    logic [PW-1:0]        outPort;
    logic [ADDR_W-1:0]    outAddr;
    logic [W-1:0]         outData;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            ldAddr[p] = load_addr[p*ADDR_W +: ADDR_W];
            wrAddr[p] = write_addr[p*ADDR_W +: ADDR_W];
            wrData[p] = write_data[p*W +: W];
        end
    end

    // A served flag only holds while ctrl stays high on the same address, so a new address re-arms the port.
    always_comb begin
        inFlight = '0;
        for (int s = 0; s < L; s++) begin
            if (pipeValid_q[s]) begin
                inFlight[pipePort_q[s]] = 1'b1;
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            wantRead[p]  = load_ctrl[p]  & ~(rdServed_q[p] & (ldAddr[p] == rdAddr_q[p]));
            wantWrite[p] = write_ctrl[p] & ~(wrServed_q[p] & (wrAddr[p] == wrSrvAddr_q[p]));
        end
        eligible = (wantRead | wantWrite) & ~inFlight;
    end

    always_comb begin
        int idx;
        grantValid = 1'b0;
        grantPort  = '0;
        idx        = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(ptr_q) + i) % NUM_PORTS;
            if (!grantValid && eligible[PW'(idx)]) begin
                grantValid = 1'b1;
                grantPort  = PW'(idx);
            end
        end
        grantValid   = grantValid & ~reset;
        grantIsWrite = wantWrite[grantPort];
        grantAddr    = grantIsWrite ? wrAddr[grantPort] : ldAddr[grantPort];
        grantInRange = ({1'b0, grantAddr} < DEPTH_LIM);
        grantIdx     = grantAddr[IW-1:0];
        readRow      = grantInRange ? mem[grantIdx] : '0;
    end

    always_ff @(posedge clock) begin
        if (grantValid && grantIsWrite && grantInRange) begin
            mem[grantIdx] <= wrData[grantPort];
        end
    end

    assign outValid = pipeValid_q[L-1];
    assign outPort  = pipePort_q[L-1];
    assign outAddr  = pipeAddr_q[L-1];
    assign outData  = pipeData_q[L-1];

    always_comb begin
        ptr_d = ptr_q;
        if (grantValid) begin
            ptr_d = (grantPort == PW'(NUM_PORTS - 1)) ? '0 : grantPort + PW'(1);
        end

        pipeValid_d    = '0;
        pipeValid_d[0] = grantValid & ~grantIsWrite;
        pipePort_d[0]  = grantPort;
        pipeAddr_d[0]  = grantAddr;
        pipeData_d[0]  = readRow;
        for (int s = 1; s < L; s++) begin
            pipeValid_d[s] = pipeValid_q[s-1];
            pipePort_d[s]  = pipePort_q[s-1];
            pipeAddr_d[s]  = pipeAddr_q[s-1];
            pipeData_d[s]  = pipeData_q[s-1];
        end

        rdServed_d = '0;
        wrServed_d = '0;
        ack_d      = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdServed_d[p]  = rdServed_q[p] & load_ctrl[p] & (ldAddr[p] == rdAddr_q[p]);
            rdAddr_d[p]    = rdAddr_q[p];
            wrServed_d[p]  = wrServed_q[p] & write_ctrl[p] & (wrAddr[p] == wrSrvAddr_q[p]);
            wrSrvAddr_d[p] = wrSrvAddr_q[p];
            if (outValid && (outPort == PW'(p))) begin
                rdServed_d[p] = 1'b1;
                rdAddr_d[p]   = outAddr;
            end
            if (grantValid && grantIsWrite && (grantPort == PW'(p))) begin
                wrServed_d[p]  = 1'b1;
                wrSrvAddr_d[p] = wrAddr[p];
                ack_d[p]       = 1'b1;
            end
        end
    end

    // Row data is not reset; the valid bits alone decide whether a stage means anything.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= '0;
            pipeValid_q <= '0;
            rdServed_q  <= '0;
            wrServed_q  <= '0;
            ack_q       <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                held_q[p]      <= '0;
                rdAddr_q[p]    <= '0;
                wrSrvAddr_q[p] <= '0;
            end
            for (int s = 0; s < L; s++) begin
                pipePort_q[s] <= '0;
                pipeAddr_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            pipeValid_q <= pipeValid_d;
            rdServed_q  <= rdServed_d;
            wrServed_q  <= wrServed_d;
            ack_q       <= ack_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                rdAddr_q[p]    <= rdAddr_d[p];
                wrSrvAddr_q[p] <= wrSrvAddr_d[p];
                if (outValid && (outPort == PW'(p))) begin
                    held_q[p] <= outData;
                end
            end
            for (int s = 0; s < L; s++) begin
                pipePort_q[s] <= pipePort_d[s];
                pipeAddr_q[s] <= pipeAddr_d[s];
            end
        end
        for (int s = 0; s < L; s++) begin
            pipeData_q[s] <= pipeData_d[s];
        end
    end

    always_comb begin
        load_valid = '0;
        load_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            load_valid[p]       = outValid && (outPort == PW'(p));
            load_data[p*W +: W] = load_valid[p] ? outData : held_q[p];
        end
    end

    assign write_ack = ack_q;
    assign busy      = |pipeValid_q;

`ifdef MEMRESP_OOR_ERR_EN
    logic          oorErr_q;
    logic [PW-1:0] oorPort_q;

    // Only the first offending grant is recorded; later ones leave the captured port alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            oorErr_q  <= 1'b0;
            oorPort_q <= '0;
        end else if (grantValid && !grantInRange && !oorErr_q) begin
            oorErr_q  <= 1'b1;
            oorPort_q <= grantPort;
        end
    end

    assign oor_err  = oorErr_q;
    assign oor_port = oorPort_q;
`endif

endmodule
